// File: rtl/frame_sequencer.sv
// Purpose : CAN receive bit-slot scheduler; tracks field class and drives one-hot decoder enables.
// Latency : 1 samplePoint; every output is a flop loaded from the next-state decode.
// Backpr. : none; advances on every samplePoint, and strobes from inactive decoders are dropped.
//
// Ports
//   samplePoint    clock, one rising edge per CAN bit sample point
//   reset          synchronous active-high reset
//   canRX          sampled bus level (1 = recessive)
//   endFrame       frame decoder EOF complete strobe
//   frameError     frame decoder stuff/CRC/form/ack error strobe
//   endOverload    overload decoder delimiter complete strobe
//   invalidBit     overload decoder illegal bit strobe
//   endError       error decoder delimiter complete strobe
//   busIdle, isFrame, isIntermission, isOverload, isError   one-hot state outputs
//   frameStart     pulse when an SOF is accepted
//   seqFault       pulse on frame watchdog expiry or overload limit exceeded
//   overloadCnt    consecutive overload frames since the last FRAME/IDLE entry
module frame_sequencer #(
  parameter int IDLE_BITS         = 11,
  parameter int INTERMISSION_BITS = 3,
  parameter int MAX_OVERLOAD      = 2,
  parameter int MAX_FRAME_BITS    = 160
) (
  input  logic       samplePoint,
  input  logic       reset,
  input  logic       canRX,
  input  logic       endFrame,
  input  logic       frameError,
  input  logic       endOverload,
  input  logic       invalidBit,
  input  logic       endError,
  output logic       busIdle,
  output logic       isFrame,
  output logic       isIntermission,
  output logic       isOverload,
  output logic       isError,
  output logic       frameStart,
  output logic       seqFault,
  output logic [1:0] overloadCnt
);

  typedef enum logic [2:0] {
    INTEGRATE,
    IDLE,
    FRAME,
    INTERMISSION,
    OVERLOAD,
    ERROR
  } state_t;

  localparam logic [7:0] IDLE_LAST  = 8'(IDLE_BITS - 1);
  localparam logic [7:0] IM_LAST    = 8'(INTERMISSION_BITS - 1);
  localparam logic [7:0] FRAME_LAST = 8'(MAX_FRAME_BITS - 1);
  localparam logic [1:0] OVL_MAX    = 2'(MAX_OVERLOAD);

  state_t     state;
  state_t     nextState;
  logic [7:0] bitCnt;
  logic [7:0] nextBitCnt;
  logic [7:0] bitCntInc;
  logic [1:0] nextOverloadCnt;
  logic       nextFrameStart;
  logic       nextSeqFault;

  // Saturating increment so a stuck counter can never wrap back into range.
  assign bitCntInc = (bitCnt == 8'hFF) ? bitCnt : bitCnt + 8'd1;

  always_comb begin
    nextState       = state;
    nextBitCnt      = bitCnt;
    nextOverloadCnt = overloadCnt;
    nextFrameStart  = 1'b0;
    nextSeqFault    = 1'b0;

    case (state)
      INTEGRATE: begin
        if (!canRX) begin
          nextBitCnt = 8'd0;
        end else if (bitCnt == IDLE_LAST) begin
          nextState  = IDLE;
          nextBitCnt = 8'd0;
        end else begin
          nextBitCnt = bitCntInc;
        end
      end

      IDLE: begin
        if (!canRX) begin
          nextState       = FRAME;
          nextBitCnt      = 8'd0;
          nextOverloadCnt = 2'd0;
          nextFrameStart  = 1'b1;
        end
      end

      FRAME: begin
        // frameError outranks endFrame; the watchdog fires only when neither strobe arrives.
        if (frameError) begin
          nextState  = ERROR;
          nextBitCnt = 8'd0;
        end else if (endFrame) begin
          nextState  = INTERMISSION;
          nextBitCnt = 8'd0;
        end else if (bitCnt == FRAME_LAST) begin
          nextState    = ERROR;
          nextBitCnt   = 8'd0;
          nextSeqFault = 1'b1;
        end else begin
          nextBitCnt = bitCntInc;
        end
      end

      INTERMISSION: begin
        if (canRX) begin
          if (bitCnt < IM_LAST) begin
            nextBitCnt = bitCntInc;
          end else begin
            nextState       = IDLE;
            nextBitCnt      = 8'd0;
            nextOverloadCnt = 2'd0;
          end
        end else if (bitCnt >= IM_LAST) begin
          // Dominant on the last intermission bit is an SOF, not an overload.
          nextState       = FRAME;
          nextBitCnt      = 8'd0;
          nextOverloadCnt = 2'd0;
          nextFrameStart  = 1'b1;
        end else if (overloadCnt < OVL_MAX) begin
          nextState       = OVERLOAD;
          nextBitCnt      = 8'd0;
          nextOverloadCnt = overloadCnt + 2'd1;
        end else begin
          nextState    = ERROR;
          nextBitCnt   = 8'd0;
          nextSeqFault = 1'b1;
        end
      end

      OVERLOAD: begin
        if (invalidBit) begin
          nextState  = ERROR;
          nextBitCnt = 8'd0;
        end else if (endOverload) begin
          nextState  = INTERMISSION;
          nextBitCnt = 8'd0;
        end
      end

      ERROR: begin
        if (endError) begin
          nextState  = INTERMISSION;
          nextBitCnt = 8'd0;
        end
      end

      default: begin
        nextState  = INTEGRATE;
        nextBitCnt = 8'd0;
      end
    endcase
  end

  // State, counters and all outputs load together so the enables are glitch-free flops.
  always_ff @(posedge samplePoint) begin
    if (reset) begin
      state          <= INTEGRATE;
      bitCnt         <= 8'd0;
      overloadCnt    <= 2'd0;
      busIdle        <= 1'b0;
      isFrame        <= 1'b0;
      isIntermission <= 1'b0;
      isOverload     <= 1'b0;
      isError        <= 1'b0;
      frameStart     <= 1'b0;
      seqFault       <= 1'b0;
    end else begin
      state          <= nextState;
      bitCnt         <= nextBitCnt;
      overloadCnt    <= nextOverloadCnt;
      busIdle        <= (nextState == IDLE);
      isFrame        <= (nextState == FRAME);
      isIntermission <= (nextState == INTERMISSION);
      isOverload     <= (nextState == OVERLOAD);
      isError        <= (nextState == ERROR);
      frameStart     <= nextFrameStart;
      seqFault       <= nextSeqFault;
    end
  end

endmodule
